// File: rtl/mgmt_apb_arbiter_if.sv
// rtl/mgmt_apb_arbiter_if.sv - APB bus bundle shared by the arbiter's requester and completer ports
interface mgmt_apb_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/mgmt_apb_arbiter.sv
// rtl/mgmt_apb_arbiter.sv - two-requester round-robin APB arbiter onto one completer
// Optional ACCESS-phase timeout enabled by defining MGMT_APB_ARB_TIMEOUT_EN.
module mgmt_apb_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               pclk,
    input  logic               preset_n,
    mgmt_apb_arbiter_if.slave  s0,
    mgmt_apb_arbiter_if.slave  s1,
    mgmt_apb_arbiter_if.master m
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  prio_q, prio_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;

    logic                  pick;
    logic                  timeout_hit;
    logic                  s0_sel;
    logic                  s1_sel;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  unused_penable;

    assign unused_penable = s0.penable ^ s1.penable;

`ifdef MGMT_APB_ARB_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of ACCESS cycles already elapsed
    assign timeout_hit = (state_q == ACCESS) && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if (state_q == ACCESS) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // pick/gnt/prio: 0 selects s0, 1 selects s1; prio_q is the tie-break winner
    assign pick = (s0.psel && s1.psel) ? prio_q : s1.psel;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        prio_d    = prio_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        case (state_q)
            IDLE: begin
                if (s0.psel || s1.psel) begin
                    state_d  = SETUP;
                    gnt_d    = pick;
                    psel_d   = 1'b1;
                    pwrite_d = pick ? s1.pwrite : s0.pwrite;
                    paddr_d  = pick ? s1.paddr  : s0.paddr;
                    pwdata_d = pick ? s1.pwdata : s0.pwdata;
                    pstrb_d  = pick ? s1.pstrb  : s0.pstrb;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (m.pready || timeout_hit) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    prio_d    = ~gnt_q;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            prio_q    <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            prio_q    <= prio_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
        end
    end

    assign m.psel    = psel_q;
    assign m.penable = penable_q;
    assign m.pwrite  = pwrite_q;
    assign m.paddr   = paddr_q;
    assign m.pwdata  = pwdata_q;
    assign m.pstrb   = pstrb_q;

    // A requester that dropped psel mid-transfer gets nothing back
    assign s0_sel   = (state_q == ACCESS) && !gnt_q && s0.psel;
    assign s1_sel   = (state_q == ACCESS) &&  gnt_q && s1.psel;
    assign rsp_err  = m.pready ? m.pslverr : timeout_hit;
    assign rsp_data = m.pready ? m.prdata  : '0;

    assign s0.pready  = s0_sel && (m.pready || timeout_hit);
    assign s0.prdata  = s0_sel ? rsp_data : '0;
    assign s0.pslverr = s0_sel && rsp_err;
    assign s1.pready  = s1_sel && (m.pready || timeout_hit);
    assign s1.prdata  = s1_sel ? rsp_data : '0;
    assign s1.pslverr = s1_sel && rsp_err;
endmodule

// File: tb/tb_mgmt_apb_arbiter.sv
// tb/tb_mgmt_apb_arbiter.sv - vector-table and directed-sequence bench for mgmt_apb_arbiter
module tb_mgmt_apb_arbiter;
    logic pclk = 1'b0;
    logic preset_n = 1'b0;

    always #5 pclk = ~pclk;

    mgmt_apb_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) s0 ();
    mgmt_apb_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) s1 ();
    mgmt_apb_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) m ();

    mgmt_apb_arbiter #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .pclk(pclk),
        .preset_n(preset_n),
        .s0(s0),
        .s1(s1),
        .m(m)
    );

    typedef struct {
        logic [1:0]  req;
        logic        wr;
        logic [15:0] addr0;
        logic [15:0] addr1;
        logic [15:0] wdata;
        logic [1:0]  strb;
        int          waits;
        logic [15:0] rdata;
        logic        err;
        logic        first;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          cmp_waits = 0;
    logic [15:0] cmp_rdata = '0;
    logic        cmp_err   = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endfunction

    // Completer model: pready after cmp_waits wait states of ACCESS
    initial begin
        int wcnt;
        wcnt = 0;
        m.pready  = 1'b0;
        m.prdata  = '0;
        m.pslverr = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            if (m.psel && m.penable) begin
                if (wcnt >= cmp_waits) begin
                    m.pready  = 1'b1;
                    m.prdata  = cmp_rdata;
                    m.pslverr = cmp_err;
                    wcnt      = 0;
                end else begin
                    m.pready  = 1'b0;
                    m.prdata  = '0;
                    m.pslverr = 1'b0;
                    wcnt++;
                end
            end else begin
                m.pready  = 1'b0;
                m.prdata  = '0;
                m.pslverr = 1'b0;
                wcnt      = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic run_vec(input int idx, input vec_t v);
        int          done_n;
        int          n_req;
        logic        w;
        logic        exp_w;
        logic [15:0] addr [2];
        logic        drop [2];
        addr[0]   = v.addr0;
        addr[1]   = v.addr1;
        n_req     = int'(v.req[0]) + int'(v.req[1]);
        cmp_waits = v.waits;
        cmp_rdata = v.rdata;
        cmp_err   = v.err;
        @(posedge pclk);
        #1;
        s0.psel = v.req[0]; s0.penable = 1'b0; s0.pwrite = v.wr; s0.paddr = v.addr0;
        s0.pwdata = v.wdata; s0.pstrb = v.strb;
        s1.psel = v.req[1]; s1.penable = 1'b0; s1.pwrite = v.wr; s1.paddr = v.addr1;
        s1.pwdata = v.wdata; s1.pstrb = v.strb;
        done_n = 0;
        for (int c = 0; c < 200 && done_n < n_req; c++) begin
            drop[0] = 1'b0;
            drop[1] = 1'b0;
            @(negedge pclk);
            if (s0.pready || s1.pready) begin
                w     = s1.pready;
                exp_w = (done_n == 0) ? v.first : ~v.first;
                chk($sformatf("v%0d_t%0d_grant", idx, done_n), w, exp_w);
                chk($sformatf("v%0d_t%0d_both_pready", idx, done_n), s0.pready & s1.pready, 0);
                chk($sformatf("v%0d_t%0d_paddr", idx, done_n), m.paddr, addr[exp_w]);
                chk($sformatf("v%0d_t%0d_pwrite", idx, done_n), m.pwrite, v.wr);
                if (v.wr) begin
                    chk($sformatf("v%0d_t%0d_pwdata", idx, done_n), m.pwdata, v.wdata);
                    chk($sformatf("v%0d_t%0d_pstrb", idx, done_n), m.pstrb, v.strb);
                end
                chk($sformatf("v%0d_t%0d_prdata", idx, done_n), w ? s1.prdata : s0.prdata, v.rdata);
                chk($sformatf("v%0d_t%0d_pslverr", idx, done_n), w ? s1.pslverr : s0.pslverr, v.err);
                chk($sformatf("v%0d_t%0d_loser_prdata", idx, done_n), w ? s0.prdata : s1.prdata, 0);
                drop[w] = 1'b1;
                done_n++;
            end
            @(posedge pclk);
            #1;
            if (drop[0]) s0.psel = 1'b0;
            if (drop[1]) s1.psel = 1'b0;
            s0.penable = s0.psel;
            s1.penable = s1.psel;
        end
        chk($sformatf("v%0d_completed", idx), done_n, n_req);
        s0.psel = 1'b0; s0.penable = 1'b0;
        s1.psel = 1'b0; s1.penable = 1'b0;
    endtask

    initial begin
        vec_t vecs [8];
        vec_t v;
        int   hits;

        s0.psel = 0; s0.penable = 0; s0.pwrite = 0; s0.paddr = 0; s0.pwdata = 0; s0.pstrb = 0;
        s1.psel = 0; s1.penable = 0; s1.pwrite = 0; s1.paddr = 0; s1.pwdata = 0; s1.pstrb = 0;

        //            req    wr    addr0     addr1     wdata     strb   w  rdata     err   first
        vecs[0] = '{2'b11, 1'b0, 16'h0100, 16'h0200, 16'h0000, 2'b00, 0, 16'h1111, 1'b0, 1'b0};
        vecs[1] = '{2'b11, 1'b1, 16'h0104, 16'h0204, 16'hA5A5, 2'b11, 1, 16'h2222, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 1'b0, 16'h0108, 16'h0000, 16'h0000, 2'b00, 1, 16'h3333, 1'b1, 1'b0};
        vecs[3] = '{2'b11, 1'b0, 16'h010C, 16'h020C, 16'h0000, 2'b00, 2, 16'h4444, 1'b0, 1'b1};
        vecs[4] = '{2'b10, 1'b1, 16'h0000, 16'h0102, 16'h55AA, 2'b01, 3, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{2'b10, 1'b0, 16'h0000, 16'h0210, 16'h0000, 2'b00, 0, 16'h1234, 1'b1, 1'b1};
        vecs[6] = '{2'b11, 1'b1, 16'h0114, 16'h0214, 16'h0F0F, 2'b10, 0, 16'h5555, 1'b0, 1'b0};
        vecs[7] = '{2'b01, 1'b0, 16'h0118, 16'h0000, 16'h0000, 2'b00, 2, 16'h6666, 1'b0, 1'b0};

        // Reset state
        @(negedge pclk);
        chk("rst_m_psel", m.psel, 0);
        chk("rst_m_penable", m.penable, 0);
        chk("rst_m_pwrite", m.pwrite, 0);
        chk("rst_m_paddr", m.paddr, 0);
        chk("rst_m_pwdata", m.pwdata, 0);
        chk("rst_m_pstrb", m.pstrb, 0);
        chk("rst_s0_pready", s0.pready, 0);
        chk("rst_s1_pready", s1.pready, 0);
        chk("rst_s0_prdata", s0.prdata, 0);
        chk("rst_s1_pslverr", s1.pslverr, 0);
        @(posedge pclk);
        #1;
        preset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Latency: s0 read 0x0010, zero wait states
        cmp_waits = 0; cmp_rdata = 16'hBEEF; cmp_err = 1'b0;
        @(posedge pclk);
        #1;
        s0.psel = 1'b1; s0.pwrite = 1'b0; s0.paddr = 16'h0010;
        @(negedge pclk);
        chk("lat_c0_m_psel", m.psel, 0);
        @(posedge pclk);
        #1;
        s0.penable = 1'b1;
        @(negedge pclk);
        chk("lat_c1_m_psel", m.psel, 1);
        chk("lat_c1_m_penable", m.penable, 0);
        chk("lat_c1_m_paddr", m.paddr, 16'h0010);
        chk("lat_c1_s0_pready", s0.pready, 0);
        @(posedge pclk);
        #1;
        @(negedge pclk);
        chk("lat_c2_m_penable", m.penable, 1);
        chk("lat_c2_s0_pready", s0.pready, 1);
        chk("lat_c2_s0_prdata", s0.prdata, 16'hBEEF);
        chk("lat_c2_s1_pready", s1.pready, 0);
        @(posedge pclk);
        #1;
        s0.psel = 1'b0; s0.penable = 1'b0;

        // s1 write with 3 wait states: request fields stable for SETUP + 4 ACCESS cycles
        cmp_waits = 3; cmp_rdata = 16'h0000; cmp_err = 1'b0;
        @(posedge pclk);
        #1;
        s1.psel = 1'b1; s1.pwrite = 1'b1; s1.paddr = 16'h0102; s1.pwdata = 16'h55AA; s1.pstrb = 2'b01;
        for (int c = 1; c <= 5; c++) begin
            @(posedge pclk);
            #1;
            s1.penable = 1'b1;
            @(negedge pclk);
            chk($sformatf("ws_c%0d_pwdata", c), m.pwdata, 16'h55AA);
            chk($sformatf("ws_c%0d_pstrb", c), m.pstrb, 2'b01);
            chk($sformatf("ws_c%0d_paddr", c), m.paddr, 16'h0102);
            chk($sformatf("ws_c%0d_m_psel", c), m.psel, 1);
            chk($sformatf("ws_c%0d_s1_pready", c), s1.pready, (c == 5) ? 1 : 0);
            chk($sformatf("ws_c%0d_s0_outs", c), {s0.pready, s0.pslverr, s0.prdata}, 0);
        end
        @(posedge pclk);
        #1;
        s1.psel = 1'b0; s1.penable = 1'b0;

        // s0 drops psel mid-transfer: transfer finishes silently, pointer still moves
        cmp_waits = 2; cmp_rdata = 16'h7777; cmp_err = 1'b0;
        @(posedge pclk);
        #1;
        s0.psel = 1'b1; s0.pwrite = 1'b0; s0.paddr = 16'h0120;
        @(posedge pclk);
        #1;
        s0.penable = 1'b1;
        @(posedge pclk);
        #1;
        s0.psel = 1'b0; s0.penable = 1'b0;
        @(posedge pclk);
        #1;
        @(posedge pclk);
        #1;
        @(negedge pclk);
        chk("drop_m_pready", m.pready, 1);
        chk("drop_m_psel", m.psel, 1);
        chk("drop_s0_pready", s0.pready, 0);
        chk("drop_s0_prdata", s0.prdata, 0);
        v = '{2'b11, 1'b0, 16'h0130, 16'h0230, 16'h0000, 2'b00, 0, 16'h8888, 1'b0, 1'b1};
        run_vec(8, v);

        // Reset pulsed during ACCESS of an s1 transfer; pointer must return to s0
        cmp_waits = 100000;
        @(posedge pclk);
        #1;
        s1.psel = 1'b1; s1.pwrite = 1'b0; s1.paddr = 16'h0240;
        @(posedge pclk);
        #1;
        s1.penable = 1'b1;
        @(posedge pclk);
        #1;
        @(negedge pclk);
        chk("rstmid_pre_penable", m.penable, 1);
        #2;
        preset_n = 1'b0;
        #1;
        chk("rstmid_m_psel", m.psel, 0);
        chk("rstmid_m_penable", m.penable, 0);
        chk("rstmid_s1_pready", s1.pready, 0);
        chk("rstmid_s0_pready", s0.pready, 0);
        s1.psel = 1'b0; s1.penable = 1'b0;
        @(posedge pclk);
        #1;
        preset_n = 1'b1;
        v = '{2'b11, 1'b0, 16'h0150, 16'h0250, 16'h0000, 2'b00, 0, 16'h9999, 1'b0, 1'b0};
        run_vec(9, v);

        // Completer never ready
        cmp_waits = 100000;
        @(posedge pclk);
        #1;
        s0.psel = 1'b1; s0.pwrite = 1'b0; s0.paddr = 16'h0160;
`ifdef MGMT_APB_ARB_TIMEOUT_EN
        for (int c = 1; c <= 10; c++) begin
            @(posedge pclk);
            #1;
            if (c == 10) begin
                s0.psel = 1'b0; s0.penable = 1'b0;
            end else begin
                s0.penable = 1'b1;
            end
            @(negedge pclk);
            if (c < 9) begin
                chk($sformatf("to_c%0d_s0_pready", c), s0.pready, 0);
            end else if (c == 9) begin
                chk("to_s0_pready", s0.pready, 1);
                chk("to_s0_pslverr", s0.pslverr, 1);
                chk("to_s0_prdata", s0.prdata, 0);
            end else begin
                chk("to_after_m_psel", m.psel, 0);
                chk("to_after_m_penable", m.penable, 0);
            end
        end
`else
        hits = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge pclk);
            #1;
            s0.penable = 1'b1;
            @(negedge pclk);
            if (s0.pready) hits++;
        end
        chk("noto_s0_pready_count", hits, 0);
        chk("noto_m_penable_held", m.penable, 1);
        s0.psel = 1'b0; s0.penable = 1'b0;
        preset_n = 1'b0;
        @(posedge pclk);
        #1;
        preset_n = 1'b1;
`endif
        @(posedge pclk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
